// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: access types,
// FSM encoding and the per-type helpers (beat count, legality, extension).
package dm_pkg;

   localparam logic [2:0] DM_WORD              = 3'b000;
   localparam logic [2:0] DM_HALFWORD          = 3'b001;
   localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
   localparam logic [2:0] DM_BYTE              = 3'b011;
   localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

   typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} dm_state_t;

   function automatic logic [2:0] dm_beats(input logic [2:0] t);
      case (t)
         DM_WORD:                           dm_beats = 3'd4;
         DM_HALFWORD, DM_HALFWORD_UNSIGNED: dm_beats = 3'd2;
         default:                           dm_beats = 3'd1;
      endcase
   endfunction

   // Unknown type, misalignment, or a store with an unsigned type.
   function automatic logic dm_illegal(input logic [2:0] t, input logic we,
                                       input logic [1:0] a_lo);
      logic half;
      half = (t == DM_HALFWORD) || (t == DM_HALFWORD_UNSIGNED);
      dm_illegal = (t > DM_BYTE_UNSIGNED)
                || ((t == DM_WORD) && (a_lo != 2'b00))
                || (half && a_lo[0])
                || (we && ((t == DM_HALFWORD_UNSIGNED) || (t == DM_BYTE_UNSIGNED)));
   endfunction

   function automatic logic [31:0] dm_extend(input logic [31:0] v, input logic [2:0] t);
      case (t)
         DM_HALFWORD:          dm_extend = {{16{v[15]}}, v[15:0]};
         DM_HALFWORD_UNSIGNED: dm_extend = {16'h0000, v[15:0]};
         DM_BYTE:              dm_extend = {{24{v[7]}}, v[7:0]};
         DM_BYTE_UNSIGNED:     dm_extend = {24'h000000, v[7:0]};
         default:              dm_extend = v;
      endcase
   endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter; the port not granted last wins a tie,
// and port 0 has priority out of reset.
module dm_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last;

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || last))
         grant = 2'b01;
      else if (req[1])
         grant = 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (accept && (grant != 2'b00))
         last <= grant[1];
   end

endmodule

// File: rtl/dm_ctrl.sv
// Shares a byte-wide single-port data RAM between two requesters, splitting
// word/halfword accesses into little-endian byte beats and extending loads.
module dm_ctrl
   import dm_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [2:0]        m0_type,
   output logic              m0_done,
   output logic              m0_err,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [2:0]        m1_type,
   output logic              m1_done,
   output logic              m1_err,
   output logic [31:0]       m1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   dm_state_t         state, state_next;
   logic              owner, we_r, err_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r, asm_r, asm_next;
   logic [2:0]        type_r, beats_r, beat;
   logic [1:0]        grant, cap_idx;
   logic              accept, sel, sel_we, sel_bad, last_beat, cap, xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [2:0]        sel_type;

   assign accept    = (state == IDLE) && (m0_req || m1_req);
   assign sel       = grant[1];
   assign sel_we    = sel ? m1_we    : m0_we;
   assign sel_addr  = sel ? m1_addr  : m0_addr;
   assign sel_wdata = sel ? m1_wdata : m0_wdata;
   assign sel_type  = sel ? m1_type  : m0_type;
   assign sel_bad   = dm_illegal(sel_type, sel_we, sel_addr[1:0]);

   dm_rr_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({m1_req, m0_req}),
      .accept (accept),
      .grant  (grant)
   );

   assign last_beat = (beat == (beats_r - 3'd1));
   assign xfer      = (state == XFER);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = sel_bad ? RESP : XFER;
         XFER:    if (last_beat) state_next = we_r ? RESP : WAIT;
         WAIT:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read data lags its strobe by a cycle, so beat k lands while beat k+1 is issued.
   assign cap     = (xfer && !we_r && (beat != 3'd0)) || (state == WAIT);
   assign cap_idx = 2'(beat - 3'd1);

   always_comb begin
      asm_next = asm_r;
      if (cap)
         asm_next[{cap_idx, 3'b000} +: 8] = mem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         we_r     <= 1'b0;
         err_r    <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= 32'h0;
         type_r   <= 3'b000;
         beats_r  <= 3'd0;
         beat     <= 3'd0;
         asm_r    <= 32'h0;
         m0_rdata <= 32'h0;
         m1_rdata <= 32'h0;
      end else begin
         state <= state_next;
         if (accept) begin
            owner   <= sel;
            we_r    <= sel_we;
            err_r   <= sel_bad;
            addr_r  <= sel_addr;
            wdata_r <= sel_wdata;
            type_r  <= sel_type;
            beats_r <= dm_beats(sel_type);
            beat    <= 3'd0;
            asm_r   <= 32'h0;
         end else begin
            if (xfer)
               beat <= beat + 3'd1;
            asm_r <= asm_next;
            // Loading rdata on the WAIT edge makes it valid alongside done.
            if (state == WAIT) begin
               if (owner)
                  m1_rdata <= dm_extend(asm_next, type_r);
               else
                  m0_rdata <= dm_extend(asm_next, type_r);
            end
         end
      end
   end

   assign mem_en    = xfer;
   assign mem_we    = xfer && we_r;
   assign mem_addr  = xfer ? addr_r + ADDR_W'(beat) : '0;
   assign mem_wdata = xfer ? wdata_r[{beat[1:0], 3'b000} +: 8] : 8'h00;

   assign m0_done = (state == RESP) && !owner;
   assign m1_done = (state == RESP) && owner;
   assign m0_err  = m0_done && err_r;
   assign m1_err  = m1_done && err_r;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: a vector table of single accesses plus
// hand-written contention, back-to-back and mid-access reset sequences.
module tb_dm_ctrl;
   import dm_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [5:0]  m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [2:0]  m0_type = '0, m1_type = '0;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic [7:0]  ram [0:63];
   logic        ram_clear = 1'b1;
   int          tests_run = 0;
   int          tests_failed = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  typ;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_r0;
      logic [31:0] exp_r1;
   } vec_t;

   vec_t vecs [15];

   dm_ctrl #(.ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_type(m0_type), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_type(m1_type), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Byte RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] allOutputs();
      return {26'd0, m0_done, m0_err, m1_done, m1_err, mem_en, mem_we}
             | {26'd0, mem_addr} | {24'd0, mem_wdata};
   endfunction

   task automatic applyStimulus(input vec_t v, output int lat, output logic err,
                                output logic en_seen, output logic other_done);
      @(posedge clk); #1;
      if (v.port) begin
         m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_type = v.typ; m1_req = 1'b1;
      end else begin
         m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_type = v.typ; m0_req = 1'b1;
      end
      lat = 0; err = 1'b0; en_seen = 1'b0; other_done = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (mem_en) en_seen = 1'b1;
         if (v.port ? m0_done : m1_done) other_done = 1'b1;
         if (v.port ? m1_done : m0_done) begin
            lat = c;
            err = v.port ? m1_err : m0_err;
            break;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat, d0a, d0b, d1, n0, first, second;
      logic        err, en_seen, other_done, hold_ok, done_seen;
      logic [31:0] r_first;

      vecs[0]  = '{1'b0, 1'b1, 6'd8, 32'hDEADBEEF, DM_WORD,              1'b0, 5, 32'h00000000, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 6'd8, 32'h0,        DM_WORD,              1'b0, 6, 32'hDEADBEEF, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 6'd3, 32'h00000080, DM_BYTE,              1'b0, 2, 32'hDEADBEEF, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 6'd3, 32'h0,        DM_BYTE,              1'b0, 3, 32'hFFFFFF80, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 6'd3, 32'h0,        DM_BYTE_UNSIGNED,     1'b0, 3, 32'h00000080, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, 6'd4, 32'h00008001, DM_HALFWORD,          1'b0, 3, 32'h00000080, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 6'd4, 32'h0,        DM_HALFWORD,          1'b0, 4, 32'hFFFF8001, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 6'd4, 32'h0,        DM_HALFWORD_UNSIGNED, 1'b0, 4, 32'h00008001, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 6'd2, 32'h0,        DM_WORD,              1'b1, 1, 32'h00008001, 32'h0};
      vecs[9]  = '{1'b0, 1'b1, 6'd5, 32'h0000BEEF, DM_HALFWORD,          1'b1, 1, 32'h00008001, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 6'd0, 32'h0,        3'b111,               1'b1, 1, 32'h00008001, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 6'd1, 32'h000000AA, DM_BYTE_UNSIGNED,     1'b1, 1, 32'h00008001, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 6'd8, 32'h0,        DM_WORD,              1'b0, 6, 32'h00008001, 32'hDEADBEEF};
      vecs[13] = '{1'b1, 1'b1, 6'd6, 32'h00001234, DM_HALFWORD,          1'b0, 3, 32'h00008001, 32'hDEADBEEF};
      vecs[14] = '{1'b1, 1'b0, 6'd6, 32'h0,        DM_HALFWORD_UNSIGNED, 1'b0, 4, 32'h00008001, 32'h00001234};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", allOutputs(), 32'h0);
      checkOutput("reset_m0_rdata", m0_rdata, 32'h0);
      checkOutput("reset_m1_rdata", m1_rdata, 32'h0);
      rst = 1'b0;
      ram_clear = 1'b0;

      // Contention: m0 wins first, then m1 beats m0's immediate re-request.
      @(posedge clk); #1;
      m0_we = 1'b1; m0_addr = 6'd20; m0_wdata = 32'h11; m0_type = DM_BYTE; m0_req = 1'b1;
      m1_we = 1'b1; m1_addr = 6'd21; m1_wdata = 32'h22; m1_type = DM_BYTE; m1_req = 1'b1;
      d0a = 0; d0b = 0; d1 = 0; n0 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (m0_done) begin
            if (n0 == 0) d0a = c; else d0b = c;
            n0++;
            if (n0 == 2) m0_req = 1'b0;
         end
         if (m1_done) begin
            d1 = c;
            m1_req = 1'b0;
         end
         if ((n0 == 2) && (d1 != 0)) break;
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      checkOutput("contend_m0_first_done", d0a, 2);
      checkOutput("contend_m1_done", d1, 5);
      checkOutput("contend_m0_second_done", d0b, 8);
      checkOutput("contend_ram20", {24'd0, ram[20]}, 32'h11);
      checkOutput("contend_ram21", {24'd0, ram[21]}, 32'h22);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i], lat, err, en_seen, other_done);
         checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         checkOutput($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         checkOutput($sformatf("v%0d_mem_en_seen", i), {31'd0, en_seen}, {31'd0, !vecs[i].exp_err});
         checkOutput($sformatf("v%0d_other_done", i), {31'd0, other_done}, 32'h0);
         checkOutput($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].exp_r0);
         checkOutput($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].exp_r1);
      end
      checkOutput("ram_word_bytes", {ram[11], ram[10], ram[9], ram[8]}, 32'hDEADBEEF);

      // Back-to-back byte loads with req held across both.
      @(posedge clk); #1;
      m0_we = 1'b0; m0_addr = 6'd3; m0_type = DM_BYTE; m0_req = 1'b1;
      first = 0; second = 0; hold_ok = 1'b1; r_first = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (m0_done) begin
            if (first == 0) begin
               first = c;
               r_first = m0_rdata;
            end else begin
               second = c;
               m0_req = 1'b0;
               break;
            end
         end else if ((first != 0) && (m0_rdata !== 32'hFFFFFF80)) begin
            hold_ok = 1'b0;
         end
      end
      m0_req = 1'b0;
      checkOutput("b2b_first_done", first, 3);
      checkOutput("b2b_second_done", second, 7);
      checkOutput("b2b_first_rdata", r_first, 32'hFFFFFF80);
      checkOutput("b2b_rdata_hold", {31'd0, hold_ok}, 32'h1);

      // Reset during beat 2 of a word store.
      @(posedge clk); #1;
      m0_we = 1'b1; m0_addr = 6'd0; m0_wdata = 32'h11223344; m0_type = DM_WORD; m0_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_beat2_mem_en", {31'd0, mem_en}, 32'h1);
      checkOutput("rst_beat2_mem_addr", {26'd0, mem_addr}, 32'd2);
      checkOutput("rst_beat2_mem_wdata", {24'd0, mem_wdata}, 32'h22);
      rst = 1'b1;
      m0_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_mid_outputs", allOutputs(), 32'h0);
      checkOutput("rst_mid_m0_rdata", m0_rdata, 32'h0);
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (m0_done || m1_done) done_seen = 1'b1;
      end
      checkOutput("rst_mid_no_done", {31'd0, done_seen}, 32'h0);
      checkOutput("rst_mid_ram_bytes", {ram[3], ram[2], ram[1], ram[0]}, 32'h80003344);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
